// File: rtl/ov7670_frame_tx.sv
// OV7670-style RGB565 frame source: pclk at clk/2, href/vsync/data updated on
// falling pclk so they are stable across the rising edge. Content is colour
// bars or a per-frame byte ramp, selected at frame start.
module ov7670_frame_tx #(
  parameter int unsigned H_ACTIVE  = 320,
  parameter int unsigned V_ACTIVE  = 240,
  parameter int unsigned H_BLANK   = 144,
  parameter int unsigned VS_LINES  = 3,
  parameter int unsigned VBP_LINES = 17,
  parameter int unsigned VFP_LINES = 10,
  parameter int unsigned BAR_W     = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       mode,
  output logic       pclk,
  output logic       href,
  output logic       vsync,
  output logic [7:0] data,
  output logic       frame_done
);

  localparam int unsigned LINE_SLOTS = 2 * H_ACTIVE + H_BLANK;
  localparam logic [10:0] BYTE_LAST  = 11'(LINE_SLOTS - 1);
  localparam logic [10:0] ACT_BYTES  = 11'(2 * H_ACTIVE);

  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBP, S_ACTIVE, S_VFP} state_t;

  state_t      state, nxt_state;
  logic        started;
  logic        mode_r;
  logic [10:0] byte_cnt, nxt_byte;
  logic [9:0]  line_cnt, nxt_line, line_last;
  logic        frame_end, nxt_href;
  logic [7:0]  ramp;
  logic [9:0]  pix_x;
  logic [31:0] bar_raw;
  logic [2:0]  bar_idx;
  logic [15:0] rgb;
  logic [7:0]  bar_byte;

  // Last line index of the vertical region currently being sent
  always_comb begin
    line_last = '0;
    unique case (state)
      S_VSYNC:  line_last = 10'(VS_LINES - 1);
      S_VBP:    line_last = 10'(VBP_LINES - 1);
      S_ACTIVE: line_last = 10'(V_ACTIVE - 1);
      S_VFP:    line_last = 10'(VFP_LINES - 1);
      default:  line_last = '0;
    endcase
  end

  // Position of the byte slot that starts at the next falling pclk
  always_comb begin
    nxt_state = state;
    nxt_byte  = byte_cnt;
    nxt_line  = line_cnt;
    frame_end = 1'b0;
    if (state == S_IDLE) begin
      if (en) begin
        nxt_state = S_VSYNC;
        nxt_byte  = '0;
        nxt_line  = '0;
      end
    end else if (byte_cnt == BYTE_LAST) begin
      nxt_byte = '0;
      if (line_cnt == line_last) begin
        nxt_line = '0;
        unique case (state)
          S_VSYNC:  nxt_state = S_VBP;
          S_VBP:    nxt_state = S_ACTIVE;
          S_ACTIVE: nxt_state = S_VFP;
          default: begin
            nxt_state = S_IDLE;
            frame_end = 1'b1;
          end
        endcase
      end else begin
        nxt_line = line_cnt + 10'd1;
      end
    end else begin
      nxt_byte = byte_cnt + 11'd1;
    end
  end

  // Colour-bar byte for the next slot; bar index saturates at the last bar
  always_comb begin
    pix_x   = nxt_byte[10:1];
    bar_raw = 32'(pix_x) / BAR_W;
    bar_idx = (bar_raw > 32'd7) ? 3'd7 : bar_raw[2:0];
    unique case (bar_idx)
      3'd0: rgb = 16'hFFFF;
      3'd1: rgb = 16'hFFE0;
      3'd2: rgb = 16'h07FF;
      3'd3: rgb = 16'h07E0;
      3'd4: rgb = 16'hF81F;
      3'd5: rgb = 16'hF800;
      3'd6: rgb = 16'h001F;
      default: rgb = 16'h0000;
    endcase
    bar_byte = nxt_byte[0] ? rgb[7:0] : rgb[15:8];
    nxt_href = (nxt_state == S_ACTIVE) && (nxt_byte < ACT_BYTES);
  end

  // Frame FSM and registered outputs; everything advances on falling pclk
  always_ff @(posedge clk) begin
    if (!rst) begin
      started    <= 1'b0;
      pclk       <= 1'b0;
      state      <= S_IDLE;
      byte_cnt   <= '0;
      line_cnt   <= '0;
      mode_r     <= 1'b0;
      ramp       <= '0;
      href       <= 1'b0;
      vsync      <= 1'b0;
      data       <= '0;
      frame_done <= 1'b0;
    end else begin
      // pclk holds low for one extra clk so its first rise lands 2 clk after reset
      started    <= 1'b1;
      if (started) pclk <= ~pclk;
      frame_done <= 1'b0;
      if (pclk) begin
        state      <= nxt_state;
        byte_cnt   <= nxt_byte;
        line_cnt   <= nxt_line;
        vsync      <= (nxt_state == S_VSYNC);
        href       <= nxt_href;
        frame_done <= frame_end;
        if (state == S_IDLE && en) begin
          mode_r <= mode;
          ramp   <= '0;
        end
        if (nxt_href) begin
          data <= mode_r ? ramp : bar_byte;
          ramp <= ramp + 8'd1;
        end else begin
          data <= '0;
        end
      end
    end
  end

endmodule
